// File: rtl/cpu_boot_sequencer.sv
// Run controller for the CPU core: byte-serial program load, reset flush window,
// then free-run / pause / single-step gating through a registered clock-enable.
module cpu_boot_sequencer #(
  parameter int ADD_WIDTH  = 8,
  parameter int INS_WIDTH  = 32,
  parameter int RST_CYCLES = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load_start,
  input  logic [ADD_WIDTH:0]   load_len,
  input  logic                 byte_valid,
  input  logic [7:0]           byte_data,
  output logic                 byte_ready,
  input  logic                 run_en,
  input  logic                 step_req,
  output logic                 pm_we,
  output logic [ADD_WIDTH-1:0] pm_waddr,
  output logic [INS_WIDTH-1:0] pm_wdata,
  output logic                 cpu_rst,
  output logic                 cpu_clk_en,
  output logic                 load_done,
  output logic [15:0]          cycle_count
);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_WRITE, S_FLUSH, S_PAUSE, S_RUN} state_t;

  localparam logic [ADD_WIDTH:0] MAX_LEN = (ADD_WIDTH+1)'(2**ADD_WIDTH);
  localparam logic [3:0]         FLUSH_LAST = 4'(RST_CYCLES - 1);

  state_t               r_state, w_next;
  logic [ADD_WIDTH:0]   r_len;
  logic [1:0]           r_bidx;
  logic [3:0]           r_fcnt;
  logic                 r_byte_ready, r_pm_we, r_cpu_rst, r_clk_en, r_load_done;
  logic [ADD_WIDTH-1:0] r_waddr;
  logic [INS_WIDTH-1:0] r_wdata;
  logic [15:0]          r_cnt;

  logic w_len_ok, w_accept, w_last_word, w_load_entry, w_step;

  assign w_len_ok    = (load_len != '0) && (load_len <= MAX_LEN);
  assign w_accept    = r_byte_ready && byte_valid;
  assign w_last_word = ({1'b0, r_waddr} + (ADD_WIDTH+1)'(1)) == r_len;

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (load_start && w_len_ok) w_next = S_LOAD;
      S_LOAD:  if (w_accept && r_bidx == 2'd3) w_next = S_WRITE;
      S_WRITE: w_next = w_last_word ? S_FLUSH : S_LOAD;
      S_FLUSH: if (r_fcnt == FLUSH_LAST) w_next = S_PAUSE;
      S_PAUSE: begin
        if (load_start && w_len_ok) w_next = S_LOAD;
        else if (run_en)            w_next = S_RUN;
      end
      S_RUN: begin
        if (load_start && w_len_ok) w_next = S_LOAD;
        else if (!run_en)           w_next = S_PAUSE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // A fresh load is any entry into LOAD that is not the return from a word write.
  assign w_load_entry = (w_next == S_LOAD) &&
                        (r_state == S_IDLE || r_state == S_PAUSE || r_state == S_RUN);
  assign w_step       = (r_state == S_PAUSE) && (w_next == S_PAUSE) && step_req;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_byte_ready <= 1'b0;
      r_pm_we      <= 1'b0;
      r_cpu_rst    <= 1'b1;
      r_clk_en     <= 1'b0;
      r_load_done  <= 1'b0;
      r_waddr      <= '0;
      r_wdata      <= '0;
      r_bidx       <= '0;
      r_fcnt       <= '0;
      r_cnt        <= '0;
    end else begin
      r_state      <= w_next;
      r_byte_ready <= (w_next == S_LOAD);
      r_pm_we      <= (w_next == S_WRITE);
      r_cpu_rst    <= (w_next == S_IDLE) || (w_next == S_LOAD) ||
                      (w_next == S_WRITE) || (w_next == S_FLUSH);
      r_clk_en     <= (w_next == S_RUN) || w_step;

      if (w_load_entry) begin
        r_waddr     <= '0;
        r_bidx      <= '0;
        r_cnt       <= '0;
        r_load_done <= 1'b0;
      end else begin
        if (r_clk_en && r_cnt != 16'hFFFF) r_cnt <= r_cnt + 16'd1;
        if (r_state == S_WRITE && !w_last_word) r_waddr <= r_waddr + ADD_WIDTH'(1);
        if (r_state == S_FLUSH && w_next == S_PAUSE) r_load_done <= 1'b1;
      end

      if (w_accept) begin
        r_wdata[8*r_bidx +: 8] <= byte_data;
        r_bidx                 <= r_bidx + 2'd1;
      end

      r_fcnt <= (r_state == S_FLUSH) ? r_fcnt + 4'd1 : 4'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (w_load_entry) r_len <= load_len;
  end

  assign byte_ready  = r_byte_ready;
  assign pm_we       = r_pm_we;
  assign pm_waddr    = r_waddr;
  assign pm_wdata    = r_wdata;
  assign cpu_rst     = r_cpu_rst;
  assign cpu_clk_en  = r_clk_en;
  assign load_done   = r_load_done;
  assign cycle_count = r_cnt;

endmodule

// File: tb/tb_cpu_boot_sequencer.sv
// Directed + randomized bench for cpu_boot_sequencer with a transaction-level model:
// expected memory writes queue, expected enable count, expected flush timing.
module tb_cpu_boot_sequencer;
  localparam int AW = 8;
  localparam int IW = 32;
  localparam int RC = 2;

  logic          clk = 1'b0;
  logic          rst, load_start, byte_valid, run_en, step_req;
  logic [AW:0]   load_len;
  logic [7:0]    byte_data;
  logic          byte_ready, pm_we, cpu_rst, cpu_clk_en, load_done;
  logic [AW-1:0] pm_waddr;
  logic [IW-1:0] pm_wdata;
  logic [15:0]   cycle_count;

  cpu_boot_sequencer #(.ADD_WIDTH(AW), .INS_WIDTH(IW), .RST_CYCLES(RC)) dut (
    .clk(clk), .rst(rst), .load_start(load_start), .load_len(load_len),
    .byte_valid(byte_valid), .byte_data(byte_data), .byte_ready(byte_ready),
    .run_en(run_en), .step_req(step_req), .pm_we(pm_we), .pm_waddr(pm_waddr),
    .pm_wdata(pm_wdata), .cpu_rst(cpu_rst), .cpu_clk_en(cpu_clk_en),
    .load_done(load_done), .cycle_count(cycle_count)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;
  int exp_cnt = 0;
  logic [31:0]      words[$];
  logic [AW+IW-1:0] exp_wr[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock, then check any program-memory write against the queue.
  task automatic tick();
    logic [AW+IW-1:0] e;
    @(posedge clk);
    #1;
    if (pm_we) begin
      chk("wr_expected", exp_wr.size() > 0, 1);
      if (exp_wr.size() > 0) begin
        e = exp_wr.pop_front();
        chk("wr_addr", 32'(pm_waddr), 32'(e[IW +: AW]));
        chk("wr_data", pm_wdata, e[IW-1:0]);
        chk("wr_rdy_low", 32'(byte_ready), 0);
      end
    end
  endtask

  task automatic chk_reset_vals();
    chk("rst_we", 32'(pm_we), 0);
    chk("rst_waddr", 32'(pm_waddr), 0);
    chk("rst_wdata", pm_wdata, 0);
    chk("rst_rdy", 32'(byte_ready), 0);
    chk("rst_cpurst", 32'(cpu_rst), 1);
    chk("rst_clken", 32'(cpu_clk_en), 0);
    chk("rst_done", 32'(load_done), 0);
    chk("rst_cnt", 32'(cycle_count), 0);
  endtask

  // mode 0: valid every cycle, 1: one cycle in three, 2: random
  task automatic do_load(input int mode);
    logic [7:0] bq[$];
    int idx, cyc;
    logic acc;
    exp_wr.delete();
    foreach (words[i]) begin
      exp_wr.push_back({AW'(i), words[i]});
      for (int b = 0; b < 4; b++) bq.push_back(words[i][8*b +: 8]);
    end
    load_len   = (AW+1)'(words.size());
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    run_en     = 1'b0;
    step_req   = 1'b0;
    exp_cnt    = 0;
    chk("ld_rdy", 32'(byte_ready), 1);
    chk("ld_cpurst", 32'(cpu_rst), 1);
    chk("ld_clken", 32'(cpu_clk_en), 0);
    chk("ld_done_clr", 32'(load_done), 0);
    chk("ld_cnt_clr", 32'(cycle_count), 0);
    idx = 0;
    cyc = 0;
    while (idx < bq.size() && cyc < 20000) begin
      byte_data  = bq[idx];
      byte_valid = (mode == 0) || (mode == 1 && cyc % 3 == 0) ||
                   (mode == 2 && $urandom_range(1, 0) == 1);
      acc = byte_valid && byte_ready;
      tick();
      cyc++;
      if (acc) idx++;
    end
    byte_valid = 1'b0;
    chk("ld_bytes_taken", idx, bq.size());
    chk("ld_all_written", exp_wr.size(), 0);
    for (int f = 0; f < RC; f++) begin
      tick();
      chk("fl_cpurst", 32'(cpu_rst), 1);
      chk("fl_done", 32'(load_done), 0);
    end
    tick();
    chk("done", 32'(load_done), 1);
    chk("done_cpurst", 32'(cpu_rst), 0);
    chk("done_clken", 32'(cpu_clk_en), 0);
  endtask

  task automatic do_steps(input int n);
    for (int s = 0; s < n; s++) begin
      step_req = 1'b1;
      tick();
      step_req = 1'b0;
      chk("step_en", 32'(cpu_clk_en), 1);
      tick();
      chk("step_off", 32'(cpu_clk_en), 0);
      exp_cnt = (exp_cnt < 65535) ? exp_cnt + 1 : 65535;
      chk("step_cnt", 32'(cycle_count), exp_cnt);
    end
  endtask

  task automatic do_run(input int n, input bit per_cycle);
    run_en = 1'b1;
    for (int c = 0; c < n; c++) begin
      tick();
      if (per_cycle) chk("run_en", 32'(cpu_clk_en), 1);
    end
    run_en = 1'b0;
    tick();
    chk("run_off", 32'(cpu_clk_en), 0);
    exp_cnt = (exp_cnt + n > 65535) ? 65535 : exp_cnt + n;
    chk("run_cnt", 32'(cycle_count), exp_cnt);
  endtask

  task automatic rand_words(input int n);
    words.delete();
    for (int i = 0; i < n; i++) words.push_back($urandom);
  endtask

  initial begin
    rst = 1'b1; load_start = 1'b0; load_len = '0; byte_valid = 1'b0;
    byte_data = '0; run_en = 1'b0; step_req = 1'b0;
    repeat (3) tick();
    chk_reset_vals();
    rst = 1'b0;
    tick();
    chk("idle_rdy", 32'(byte_ready), 0);

    // Illegal lengths are ignored in IDLE
    load_len = '0; load_start = 1'b1;
    tick();
    load_start = 1'b0;
    tick();
    chk("len0_rdy", 32'(byte_ready), 0);
    chk("len0_cpurst", 32'(cpu_rst), 1);
    load_len = (AW+1)'(2**AW + 1); load_start = 1'b1;
    tick();
    load_start = 1'b0;
    tick();
    chk("lenbig_rdy", 32'(byte_ready), 0);

    // T1 / T2 fixed words, full-rate then throttled
    words = '{32'h12345678, 32'hDEADBEEF};
    do_load(0);
    do_load(1);

    // T3 single steps, then held step_req steps every cycle
    do_steps(3);
    chk("t3_cnt", 32'(cycle_count), 3);
    step_req = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("hold_step_en", 32'(cpu_clk_en), 1);
    end
    step_req = 1'b0;
    tick();
    chk("hold_step_off", 32'(cpu_clk_en), 0);
    exp_cnt += 4;
    tick();
    chk("hold_step_cnt", 32'(cycle_count), exp_cnt);

    // T4 fresh load then run 10
    rand_words($urandom_range(4, 1));
    do_load(2);
    do_run(10, 1'b1);
    chk("t4_cnt", 32'(cycle_count), 10);

    // Random mix of runs and steps, step_req ignored while running
    for (int r = 0; r < 6; r++) begin
      step_req = $urandom_range(1, 0) == 1;
      do_run($urandom_range(12, 1), 1'b1);
      step_req = 1'b0;
      do_steps($urandom_range(3, 0));
      tick();
      chk("mix_idle", 32'(cpu_clk_en), 0);
    end

    // Full-depth load: addresses 0..255 without wrap
    rand_words(2**AW);
    do_load(0);

    // Saturation
    rand_words(1);
    do_load(2);
    do_run(65534, 1'b0);
    chk("sat_fffe", 32'(cycle_count), 32'hFFFE);
    do_run(5, 1'b1);
    chk("sat_ffff", 32'(cycle_count), 32'hFFFF);

    // T6 load_start wins over run_en and step_req while running
    run_en = 1'b1;
    tick();
    chk("t6_running", 32'(cpu_clk_en), 1);
    step_req = 1'b1;
    rand_words(3);
    do_load(2);

    // T5 reset mid-word discards the partial word
    load_len = (AW+1)'(1); load_start = 1'b1;
    tick();
    load_start = 1'b0;
    byte_valid = 1'b1; byte_data = 8'hA5;
    tick();
    byte_data = 8'h5A;
    tick();
    byte_valid = 1'b0;
    rst = 1'b1;
    tick();
    chk_reset_vals();
    rst = 1'b0;
    tick();
    chk("t5_idle_rdy", 32'(byte_ready), 0);
    rand_words(1);
    do_load(0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #10ms;
    $display("FAIL timeout: observed no finish, expected finish");
    $fatal(1, "timeout");
  end
endmodule
